reg_write_scoreboard: RTL

REG_WRITE_SCOREBOARD -- requirements
Module: reg_write_scoreboard

---
 rtl/reg_write_scoreboard.sv | 95 +++++++++
 1 files changed

// File: rtl/reg_write_scoreboard.sv
// rtl/reg_write_scoreboard.sv - GPR writer tracking for load-use stall and operand forwarding
// Three writer slots (EX, MEM, WB) shift every cycle; decode operands are matched against them.
module reg_write_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dValid,
  input  logic [31:0]      dInst,
  input  logic             dUseRs,
  input  logic             dUseRt,
  input  logic             dWrEn,
  input  logic [4:0]       dWrReg,
  input  logic             dIsLoad,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwdRs,
  output logic [1:0]       fwdRt,
  output logic [CNT_W-1:0] stallCount
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;

  logic [4:0] rs, rt;
  logic       rs_ex, rs_mem, rs_wb;
  logic       rt_ex, rt_mem, rt_wb;
  logic       ex_load_en;
  logic       unused_inst_bits;

  assign rs = dInst[25:21];
  assign rt = dInst[20:16];
  assign unused_inst_bits = ^{dInst[31:26], dInst[15:0]};

  // Register 0 never matches, so reads of $0 always come from the regfile.
  function automatic logic slot_hit(input logic v, input logic use_op,
                                    input logic [4:0] r, input slot_t s);
    return v && use_op && (r != 5'd0) && s.valid && (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic e, input logic m, input logic w);
    if (e)      return 2'd1;
    else if (m) return 2'd2;
    else if (w) return 2'd3;
    else        return 2'd0;
  endfunction

  always_comb begin
    rs_ex  = slot_hit(dValid, dUseRs, rs, ex_q);
    rs_mem = slot_hit(dValid, dUseRs, rs, mem_q);
    rs_wb  = slot_hit(dValid, dUseRs, rs, wb_q);
    rt_ex  = slot_hit(dValid, dUseRt, rt, ex_q);
    rt_mem = slot_hit(dValid, dUseRt, rt, mem_q);
    rt_wb  = slot_hit(dValid, dUseRt, rt, wb_q);

    stall = (rs_ex || rt_ex) && ex_q.is_load && !flush;

    if (stall || !dValid) begin
      fwdRs = 2'd0;
      fwdRt = 2'd0;
    end else begin
      fwdRs = fwd_sel(rs_ex, rs_mem, rs_wb);
      fwdRt = fwd_sel(rt_ex, rt_mem, rt_wb);
    end

    ex_load_en = dValid && dWrEn && !stall && !flush && (dWrReg != 5'd0);
  end

  // A stalled or flushed decode inserts a bubble; the pipeline behind it keeps draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      stallCount <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (ex_load_en) begin
        ex_q <= '{valid: 1'b1, rd: dWrReg, is_load: dIsLoad};
      end else begin
        ex_q <= '0;
      end
      if (stall) begin
        stallCount <= stallCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
